// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags, flush,
// registered read data with valid strobe, and overflow/underflow pulses.
module fifo_sync_param #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 14,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     en_write,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     en_read,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             rd_ok, wr_ok, mem_we;

    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (32'(count_q) >= AF_THRESH);
    assign almost_empty = (32'(count_q) <= AE_THRESH);

    always_comb begin
        rd_ok        = en_read & ~empty;
        // A read on the same edge frees the slot, so a full FIFO still accepts the write.
        wr_ok        = en_write & (~full | en_read);
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        overflow_d   = 1'b0;
        underflow_d  = 1'b0;
        mem_we       = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            mem_we      = wr_ok;
            overflow_d  = en_write & ~wr_ok;
            underflow_d = en_read & ~rd_ok;
            if (wr_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                data_out_d   = mem_q[rd_ptr_q];
                data_valid_d = 1'b1;
            end
            if (wr_ok && !rd_ok) begin
                count_d = count_q + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    // Storage is never cleared; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule
